uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQUENCY, default 125000000, meaning system clock frequency in Hz.
REQ-002 Parameter UART_FREQUENCY, default 9600, meaning baud rate in bit/s.
REQ-003 i_clock  input  1  system clock; all logic on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_rx  input  1  asynchronous serial line; idle high.
REQ-006 i_ready  input  1  consumer accepts o_data while o_valid is high.
REQ-007 o_data  output  8  last received byte.
REQ-008 o_valid  output  1  o_data holds an unconsumed byte.
REQ-009 o_frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 o_overrun  output  1  one-cycle pulse: byte dropped because o_valid was still high.
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 CLKS_PER_BIT SHALL be CLK_FREQUENCY/UART_FREQUENCY, truncated (13020 at defaults); HALF_BIT SHALL be CLKS_PER_BIT/2 (6510).
REQ-014 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 States SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE->START on a synchronized high-to-low transition; the bit counter clears.
REQ-017 START: at HALF_BIT-1 cycles, sample the line; low -> DATA, counter cleared; high -> IDLE (false start, no output change).
REQ-018 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift into the LSB-first register; after the 8th sample -> STOP.
REQ-019 STOP: sample at mid-bit; high -> byte complete; low -> o_frame_error pulses for 1 cycle, byte discarded; either case -> IDLE on the same edge.
REQ-020 Byte complete with o_valid low, or with o_valid high and i_ready high in the same cycle: o_data loads the byte and o_valid is 1 on the next cycle.
REQ-021 Byte complete with o_valid high and i_ready low: byte dropped, o_data unchanged, o_overrun pulses for 1 cycle.
REQ-022 o_valid SHALL clear on the cycle after o_valid&&i_ready unless REQ-020 reloads it.
REQ-023 Falling-edge detection SHALL be the only start trigger; a line held low after a framing error SHALL NOT retrigger until it returns high.
REQ-024 Nominal latency: o_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT (+-1) cycles after the falling start edge reaches i_rx.
REQ-025 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL NOT wrap within a bit period.

Reset
REQ-026 When i_reset is high: state IDLE, counters 0, shift register 0, o_data 0, o_valid 0, o_frame_error 0, o_overrun 0, o_busy 0; synchronizer flops 1 (idle line).
REQ-027 Reset mid-frame SHALL abort the frame with no output pulse; reception resumes at the next falling edge after release.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding, the frame width (8) and the CLKS_PER_BIT/HALF_BIT derivation for reuse by uart_tx.
REQ-029 One sub-module, uart_rx_sync (2-flop synchronizer plus falling-edge detect), SHALL be instantiated; the FSM, counters and output register stay in uart_rx.

Verification
REQ-030 Bench driver SHALL be uart_tx at 125 MHz/9600 with i_ready tied high; send 0x80 -> one o_valid, o_data=0x80, no error or overrun pulse.
REQ-031 Low glitch of 2000 cycles on i_rx -> o_busy high then low, returns to IDLE, o_valid stays 0.
REQ-032 Hand-built frame 0x55 with stop bit low -> exactly one o_frame_error pulse, o_valid stays 0; next frame 0x0F received correctly.
REQ-033 With i_ready low, send 0xA5 then 0x3C -> o_data=0xA5 held, o_overrun pulses once at the 0x3C stop sample; raise i_ready -> o_valid clears next cycle.
REQ-034 Assert i_reset during the 4th data bit of 0xFF -> all outputs 0 asynchronously; after release, 0x01 is received correctly.
REQ-035 Back-to-back 0x00 and 0xFF with no idle gap, i_ready high -> two o_valid events, in order, with correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and bit-timing derivation.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DataBits = 8;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud_hz);
        return clk_hz / baud_hz;
    endfunction

    function automatic int unsigned half_bit(input int unsigned clk_hz,
                                             input int unsigned baud_hz);
        return clks_per_bit(clk_hz, baud_hz) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synced value.
// All flops reset to 1 so that reset looks like an idle line.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic rx_fall_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rx_sync_o = sync2_q;
    assign rx_fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1: samples each bit at mid-period and holds the last byte in a
// valid/ready output register with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY  = 125000000,
    parameter int unsigned UART_FREQUENCY = 9600
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_rx,
    input  logic                i_ready,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    output logic                o_frame_error,
    output logic                o_overrun,
    output logic                o_busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQUENCY, UART_FREQUENCY);
    localparam int unsigned HalfBit    = half_bit(CLK_FREQUENCY, UART_FREQUENCY);
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned IdxW       = $clog2(DataBits);

    localparam logic [CntW-1:0] BitLast    = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfLast   = CntW'(HalfBit - 1);
    localparam logic [IdxW-1:0] BitIdxLast = IdxW'(DataBits - 1);

    logic rx_sync, rx_fall;

    uart_rx_sync u_sync (
        .clk_i     (i_clock),
        .rst_i     (i_reset),
        .rx_i      (i_rx),
        .rx_sync_o (rx_sync),
        .rx_fall_o (rx_fall)
    );

    uart_state_e         state_q;
    logic [CntW-1:0]     cnt_q;
    logic [IdxW-1:0]     bit_idx_q;
    logic [DataBits-1:0] shift_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (rx_fall) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (!rx_sync) begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end else begin
                            // Line was high again at mid start bit: glitch, not a frame.
                            state_q <= StIdle;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[DataBits-1:1]};
                        if (bit_idx_q == BitIdxLast) begin
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        o_busy  <= 1'b0;
                        if (!rx_sync) begin
                            o_frame_error <= 1'b1;
                        end else if (!o_valid || i_ready) begin
                            // A same-cycle handshake frees the register for the new byte.
                            o_data  <= shift_q;
                            o_valid <= 1'b1;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural line driver plus a frame-level reference
// model push expected events; a monitor pops them as the receiver reports.
module tb_uart_rx;

    localparam int unsigned ClkFreq = 6_400_000;
    localparam int unsigned Baud    = 100_000;
    localparam int          Cpb     = ClkFreq / Baud;
    localparam int          Half    = Cpb / 2;
    localparam int          Latency = 2 + Half + 9 * Cpb;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;

    always #5 clock = ~clock;

    uart_rx #(
        .CLK_FREQUENCY  (ClkFreq),
        .UART_FREQUENCY (Baud)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_rx          (rx),
        .i_ready       (ready),
        .o_data        (data),
        .o_valid       (valid),
        .o_frame_error (ferr),
        .o_overrun     (ovr),
        .o_busy        (busy)
    );

    typedef enum int {EvByte, EvFerr, EvOvr} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  occupied = 1'b0;
    time t_start = 0;
    time t_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic check_event(input ev_kind_e kind, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %0h, want none", kind, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EvByte && e.data !== d)) begin
                errors++;
                $display("FAIL event: got kind %0d data %0h, want kind %0d data %0h",
                         kind, d, e.kind, e.data);
            end
        end
        if (kind == EvByte) t_valid = $time;
    endtask

    // Reference model: what a receiver must report for one frame, given the consumer state.
    task automatic expect_frame(input logic [7:0] b, input logic stop);
        if (!stop) begin
            exp_q.push_back(ev_t'{EvFerr, 8'h00});
        end else if (occupied && !ready) begin
            exp_q.push_back(ev_t'{EvOvr, 8'h00});
        end else begin
            exp_q.push_back(ev_t'{EvByte, b});
            occupied = !ready;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (Cpb) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_start = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: a new byte is o_valid rising, or o_valid staying high after a handshake.
    initial begin
        bit pv, pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                if (valid && (!pv || pr)) check_event(EvByte, data);
                if (ferr) check_event(EvFerr, 8'h00);
                if (ovr) check_event(EvOvr, 8'h00);
            end
            pv = valid;
            pr = ready;
        end
    end

    initial begin
        longint lat;
        bit     seen_busy;
        logic [7:0] b;
        logic       stop;

        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        wait_cycles(5);
        check("reset_data", data, 0);
        check("reset_valid", valid, 0);
        check("reset_ferr", ferr, 0);
        check("reset_ovr", ovr, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        wait_cycles(5);

        // Single byte and start-to-valid latency.
        expect_frame(8'h80, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_cycles(Cpb);
        lat = longint'(t_valid - t_start - 6) / 10;
        check("latency_in_window", (lat >= Latency - 1 && lat <= Latency + 1), 1);
        check("data_0x80", data, 8'h80);
        check("valid_consumed", valid, 0);
        check("q_after_0x80", exp_q.size(), 0);

        // Short low glitch: receiver wakes up, rejects it at mid start bit.
        seen_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < Half / 2; i++) begin
            @(negedge clock);
            if (busy) seen_busy = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < Cpb; i++) begin
            @(negedge clock);
            if (busy) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", seen_busy, 1);
        check("glitch_busy_idle", busy, 0);
        check("glitch_no_valid", valid, 0);

        // Framing error, line held low afterwards must not retrigger.
        expect_frame(8'h55, 1'b0);
        send_frame(8'h55, 1'b0);
        wait_cycles(Cpb);
        rx = 1'b1;
        wait_cycles(Cpb);
        check("q_after_ferr", exp_q.size(), 0);
        check("ferr_no_valid", valid, 0);
        expect_frame(8'h0F, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_cycles(Cpb);
        check("data_0x0f", data, 8'h0F);

        // Overrun while the consumer stalls.
        ready = 1'b0;
        expect_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_cycles(Cpb);
        check("ovr_data_held", data, 8'hA5);
        check("ovr_valid_held", valid, 1);
        check("q_after_ovr", exp_q.size(), 0);
        ready = 1'b1;
        @(negedge clock);
        check("valid_cleared_after_ready", valid, 0);
        occupied = 1'b0;
        wait_cycles(4);

        // Reset in the middle of the 4th data bit of 0xFF.
        t_start = $time;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        wait_cycles(Half);
        check("busy_before_reset", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_data", data, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_ferr_ovr", {ferr, ovr}, 0);
        @(negedge clock);
        wait_cycles(6 * Cpb);
        reset = 1'b0;
        occupied = 1'b0;
        wait_cycles(4);
        expect_frame(8'h01, 1'b1);
        send_frame(8'h01, 1'b1);
        wait_cycles(Cpb);
        check("data_after_reset", data, 8'h01);

        // Back-to-back frames with no idle gap.
        expect_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1);
        expect_frame(8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(Cpb);
        check("q_after_b2b", exp_q.size(), 0);
        check("data_b2b_last", data, 8'hFF);

        // Random traffic with occasional bad stop bits.
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            expect_frame(b, stop);
            send_frame(b, stop);
            if (!stop) drive_bit(1'b1);
            rx = 1'b1;
            wait_cycles(int'($urandom_range(0, Cpb / 4)));
        end
        wait_cycles(2 * Cpb);
        check("q_final_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
